// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared definitions for the instruction fetch stage.
//   S_IDLE/S_FETCH/S_HOLD  fetch FSM state encodings
//   NOP                    instruction word loaded into IF/ID on reset
//   DEFAULT_RESET_VECTOR   default address of the first fetch after reset
package instr_fetch_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory bus between the fetch stage and memory.
//   imem_req     fetch request (driven by the fetch stage)
//   imem_addr    fetch address (driven by the fetch stage)
//   imem_rvalid  fetched word valid, one pulse per request (driven by memory)
//   imem_rdata   fetched word (driven by memory)
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch_pc_gen.sv
// fetch_pc_gen: program counter, pending-redirect latch and next-pc selection.
//   clk, rst_n  clock, asynchronous active-low reset
//   advance     the word in IF moves to IF/ID this cycle, so pc steps on
//   taken       ID resolves a taken branch this cycle
//   branch_pc   branch target; the low two bits are dropped
//   pc          address of the instruction currently in IF
module fetch_pc_gen
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        taken,
    input  logic [31:0] branch_pc,
    output logic [31:0] pc
);
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic [31:0] target;
    logic [31:0] next_pc;

    assign target  = {branch_pc[31:2], 2'b00};
    // A redirect latched while the delay slot was still in flight beats a
    // fresh branch; otherwise fall through sequentially (wraps at 2^32).
    assign next_pc = redir_valid ? redir_pc : taken ? target : pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_VECTOR;
            redir_valid <= 1'b0;
            redir_pc    <= 32'h0;
        end else begin
            if (advance)
                pc <= next_pc;
            // The target is remembered only until the delay slot leaves IF.
            if (advance)
                redir_valid <= 1'b0;
            else if (taken) begin
                redir_valid <= 1'b1;
                redir_pc    <= target;
            end
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: MIPS-style fetch stage with one outstanding memory request,
// a one-entry hold buffer for stalls and branch delay-slot handling.
//   clk, rst_n  clock, asynchronous active-low reset
//   imem        instruction memory bus (master side)
//   stall       ID cannot accept an instruction this cycle
//   is_branch   ID instruction redirects control flow
//   branch_pc   redirect target
//   pc_out      PC of the instruction currently in IF
//   id_instr    IF/ID instruction register
//   id_pc       IF/ID PC register
//   id_valid    IF/ID holds a real instruction
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_if.master        imem,
    input  logic                 stall,
    input  logic                 is_branch,
    input  logic [31:0]          branch_pc,
    output logic [31:0]          pc_out,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc,
    output logic                 id_valid
);
    logic [1:0]  state;
    logic [31:0] hold_instr;
    logic [31:0] pc;
    logic        got_word;
    logic        xfer;
    logic        taken;

    // rvalid only counts while a request is outstanding.
    assign got_word = state == S_FETCH && imem.imem_rvalid;
    assign xfer     = !stall && (got_word || state == S_HOLD);
    assign taken    = id_valid && is_branch && !stall;

    fetch_pc_gen #(.RESET_VECTOR(RESET_VECTOR)) u_pc_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (xfer),
        .taken     (taken),
        .branch_pc (branch_pc),
        .pc        (pc)
    );

    assign pc_out         = pc;
    assign imem.imem_addr = pc;
    assign imem.imem_req  = state == S_FETCH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hold_instr <= NOP;
            id_instr   <= NOP;
            id_pc      <= 32'h0;
            id_valid   <= 1'b0;
        end else begin
            state <= state == S_IDLE  ? S_FETCH :
                     state == S_FETCH ? (got_word && stall ? S_HOLD : S_FETCH) :
                     stall            ? S_HOLD : S_FETCH;
            if (got_word && stall)
                hold_instr <= imem.imem_rdata;
            if (xfer) begin
                id_instr <= state == S_HOLD ? hold_instr : imem.imem_rdata;
                id_pc    <= pc;
                id_valid <= 1'b1;
            end else if (!stall)
                id_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch against a program-order
// reference model (delivered PCs follow pc+4, with a taken branch's target
// appearing right after its delay slot).
module tb_instr_fetch;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        is_branch = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic [31:0] pc_out, id_instr, id_pc;
    logic        id_valid;

    instr_fetch_if bus();

    instr_fetch #(.RESET_VECTOR(RV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem      (bus),
        .stall     (stall),
        .is_branch (is_branch),
        .branch_pc (branch_pc),
        .pc_out    (pc_out),
        .id_instr  (id_instr),
        .id_pc     (id_pc),
        .id_valid  (id_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Memory responder and reference model state.
    int          lat = 0;
    int          wcnt = 0;
    logic [31:0] exp_pc;
    logic [31:0] m_ipc, m_instr, redir_tgt;
    logic        m_idv, have_word, redir_pend, just_deliv;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        exp_pc = RV; m_idv = 1'b0; m_ipc = 32'h0; m_instr = 32'h0;
        have_word = 1'b0; redir_pend = 1'b0; redir_tgt = 32'h0;
        just_deliv = 1'b0; wcnt = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; stall = 1'b0; is_branch = 1'b0; bus.imem_rvalid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs at the negedge, answer memory, advance model.
    task automatic step(input logic st, input logic br, input logic [31:0] bpc);
        logic dl;
        stall = st; is_branch = br; branch_pc = bpc;
        bus.imem_rvalid = 1'b0;
        if (bus.imem_req) begin
            if (wcnt >= lat) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = word_at(bus.imem_addr);
                wcnt = 0;
                have_word = 1'b1;
            end else
                wcnt++;
        end
        if (m_idv && br && !st) begin
            redir_pend = 1'b1;
            redir_tgt  = {bpc[31:2], 2'b00};
        end
        dl = have_word && !st;
        @(posedge clk);
        #1;
        just_deliv = dl;
        if (dl) begin
            m_idv = 1'b1; m_ipc = exp_pc; m_instr = word_at(exp_pc);
            exp_pc = redir_pend ? redir_tgt : exp_pc + 32'd4;
            redir_pend = 1'b0; have_word = 1'b0;
        end else if (!st)
            m_idv = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.imem_req); else passes++;
        checks++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid: got %b want 0", id_valid); else passes++;
        checks++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr: got %h want 00000000", id_instr); else passes++;
        checks++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc: got %h want 00000000", id_pc); else passes++;
        checks++; if (pc_out !== RV) $display("FAIL reset_pc_out: got %h want %h", pc_out, RV); else passes++;
        step(1'b0, 1'b0, 32'h0);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RV)
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RV); else passes++;
    endtask

    task automatic test_sequential();
        int n = 0;
        logic [31:0] want;
        apply_reset();
        lat = 1;
        for (int c = 0; c < 40 && n < 3; c++) begin
            step(1'b0, 1'b0, 32'h0);
            if (just_deliv) begin
                want = RV + 32'(n * 4);
                checks++; if (id_valid !== 1'b1 || id_pc !== want || id_instr !== word_at(want))
                    $display("FAIL seq_deliver%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", n, id_valid, id_pc, id_instr, want, word_at(want)); else passes++;
                checks++; if (bus.imem_addr !== want + 32'd4)
                    $display("FAIL seq_addr%0d: got %h want %h", n, bus.imem_addr, want + 32'd4); else passes++;
                n++;
            end
        end
        checks++; if (n != 3) $display("FAIL seq_timeout: got %0d deliveries want 3", n); else passes++;
    endtask

    task automatic test_branch_same();
        apply_reset();
        lat = 0;
        for (int c = 0; c < 40 && !(just_deliv && m_ipc == 32'h10); c++) step(1'b0, 1'b0, 32'h0);
        checks++; if (!(just_deliv && m_ipc == 32'h10)) $display("FAIL bs_reach: got no delivery of 00000010 want one"); else passes++;
        step(1'b0, 1'b1, 32'h100);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h14 || id_instr !== word_at(32'h14))
            $display("FAIL bs_delay_slot: got v=%b pc=%h want v=1 pc=00000014", id_valid, id_pc); else passes++;
        checks++; if (bus.imem_addr !== 32'h100) $display("FAIL bs_target_addr: got %h want 00000100", bus.imem_addr); else passes++;
        step(1'b0, 1'b0, 32'h0);
        checks++; if (id_pc !== 32'h100 || id_instr !== word_at(32'h100))
            $display("FAIL bs_target_deliver: got pc=%h want 00000100", id_pc); else passes++;
    endtask

    task automatic test_branch_late();
        logic saw18 = 1'b0;
        apply_reset();
        lat = 0;
        for (int c = 0; c < 40 && !(just_deliv && m_ipc == 32'h10); c++) step(1'b0, 1'b0, 32'h0);
        lat = 3;
        step(1'b0, 1'b1, 32'h100);
        checks++; if (id_valid !== 1'b0 || bus.imem_addr !== 32'h14)
            $display("FAIL bl_bubble: got v=%b addr=%h want v=0 addr=00000014", id_valid, bus.imem_addr); else passes++;
        for (int c = 0; c < 20 && !just_deliv; c++) begin
            step(1'b0, 1'b0, 32'h0);
            if (bus.imem_addr === 32'h18) saw18 = 1'b1;
        end
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h14 || id_instr !== word_at(32'h14))
            $display("FAIL bl_delay_slot: got v=%b pc=%h want v=1 pc=00000014", id_valid, id_pc); else passes++;
        checks++; if (bus.imem_addr !== 32'h100 || saw18)
            $display("FAIL bl_redirect: got addr=%h saw18=%b want addr=00000100 saw18=0", bus.imem_addr, saw18); else passes++;
        step(1'b0, 1'b0, 32'h0);
        for (int c = 0; c < 20 && !just_deliv; c++) step(1'b0, 1'b0, 32'h0);
        checks++; if (id_pc !== 32'h100 || id_instr !== word_at(32'h100))
            $display("FAIL bl_target_deliver: got pc=%h want 00000100", id_pc); else passes++;
    endtask

    task automatic test_hold();
        apply_reset();
        lat = 1;
        for (int c = 0; c < 60 && !(just_deliv && m_ipc == 32'h1c); c++) step(1'b0, 1'b0, 32'h0);
        checks++; if (!(just_deliv && m_ipc == 32'h1c)) $display("FAIL hold_reach: got no delivery of 0000001c want one"); else passes++;
        step(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'h0);
            checks++; if (bus.imem_req !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h1c)
                $display("FAIL hold_cycle%0d: got req=%b v=%b pc=%h want req=0 v=0 pc=0000001c", k, bus.imem_req, id_valid, id_pc); else passes++;
        end
        step(1'b0, 1'b0, 32'h0);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_instr !== word_at(32'h20))
            $display("FAIL hold_release: got v=%b pc=%h instr=%h want v=1 pc=00000020 instr=%h", id_valid, id_pc, id_instr, word_at(32'h20)); else passes++;
        step(1'b0, 1'b0, 32'h0);
        checks++; if (id_valid !== 1'b0 || bus.imem_addr !== 32'h24)
            $display("FAIL hold_once: got v=%b addr=%h want v=0 addr=00000024", id_valid, bus.imem_addr); else passes++;
    endtask

    task automatic test_wrap();
        apply_reset();
        lat = 0;
        for (int c = 0; c < 40 && !(just_deliv && m_ipc == 32'h8); c++) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target: got %h want fffffffc", bus.imem_addr); else passes++;
        step(1'b0, 1'b0, 32'h0);
        checks++; if (bus.imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC)
            $display("FAIL wrap_addr: got addr=%h pc=%h want addr=00000000 pc=fffffffc", bus.imem_addr, id_pc); else passes++;
        step(1'b0, 1'b1, 32'h103);
        checks++; if (bus.imem_addr !== 32'h100 || id_pc !== 32'h0)
            $display("FAIL wrap_align: got addr=%h pc=%h want addr=00000100 pc=00000000", bus.imem_addr, id_pc); else passes++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        lat = 5;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || id_valid !== 1'b0)
            $display("FAIL rmid_async: got req=%b v=%b want req=0 v=0", bus.imem_req, id_valid); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RV || id_valid !== 1'b0)
            $display("FAIL rmid_late_rvalid: got req=%b addr=%h v=%b want req=1 addr=%h v=0", bus.imem_req, bus.imem_addr, id_valid, RV); else passes++;
        @(negedge clk);
        lat = 1;
        for (int c = 0; c < 20 && !just_deliv; c++) step(1'b0, 1'b0, 32'h0);
        checks++; if (id_valid !== 1'b1 || id_pc !== RV || id_instr !== word_at(RV))
            $display("FAIL rmid_first: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", id_valid, id_pc, id_instr, RV, word_at(RV)); else passes++;
    endtask

    task automatic test_random();
        int bad = 0;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0, $urandom & 32'h0000_03FF);
            checks++; if (bus.imem_req !== !have_word || bus.imem_addr !== exp_pc || pc_out !== exp_pc) begin
                if (bad++ < 10) $display("FAIL rand_fetch@%0d: got req=%b addr=%h pc_out=%h want req=%b addr=%h", c, bus.imem_req, bus.imem_addr, pc_out, !have_word, exp_pc);
            end else passes++;
            checks++; if (id_valid !== m_idv || (m_idv && (id_pc !== m_ipc || id_instr !== m_instr))) begin
                if (bad++ < 10) $display("FAIL rand_ifid@%0d: got v=%b pc=%h instr=%h want v=%b pc=%h instr=%h", c, id_valid, id_pc, id_instr, m_idv, m_ipc, m_instr);
            end else passes++;
        end
    endtask

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        model_reset();
        test_reset();
        test_sequential();
        test_branch_same();
        test_branch_late();
        test_hold();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
